// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: one-hot grant, address/data-phase owner tracking,
// grant hold for fixed-length bursts and locked sequences, parking on a default master.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   Hclk,
    input  logic                   Hresetn,
    input  logic [NUM_MASTERS-1:0] Hbusreq,
    input  logic [NUM_MASTERS-1:0] Hlock,
    input  logic [1:0]             Htrans,
    input  logic [2:0]             Hburst,
    input  logic                   Hready,
    input  logic [1:0]             Hresp,
    output logic [NUM_MASTERS-1:0] Hgrant,
    output logic [3:0]             Hmaster,
    output logic [3:0]             Hmaster_d,
    output logic                   Hmastlock,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {ARB = 2'd0, BURST = 2'd1, LOCK = 2'd2} state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [1:0] RESP_ERR  = 2'b01;
    localparam logic [3:0] DEF_IDX   = 4'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
        {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    state_t                 state;
    state_t                 state_nxt;
    logic [3:0]             beats_left;
    logic [3:0]             beats_nxt;
    logic [3:0]             last_grant;
    logic [3:0]             g_idx;
    logic [3:0]             arb_idx;
    logic                   any_req;
    logic [NUM_MASTERS-1:0] arb_grant;
    logic [15:0]            req_ext;
    logic [15:0]            lock_ext;
    logic                   burst_start;
    logic                   burst_done;
    logic                   abort;
    logic                   do_arb;
    logic [3:0]             burst_len;

    assign req_ext   = 16'(Hbusreq);
    assign lock_ext  = 16'(Hlock);
    assign dbg_state = state;

    // Index of the current grant and round-robin winner starting after last_grant.
    always_comb begin
        logic [3:0] cand;
        g_idx     = DEF_IDX;
        arb_idx   = DEF_IDX;
        any_req   = 1'b0;
        arb_grant = '0;
        cand      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (Hgrant[i]) g_idx = 4'(i);
        end
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = 4'((int'(last_grant) + i) % NUM_MASTERS);
            if (!any_req && req_ext[cand]) begin
                any_req = 1'b1;
                arb_idx = cand;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            arb_grant[i] = (arb_idx == 4'(i));
        end
    end

    // Beat counter: loaded on a burst NONSEQ when idle, counted down by SEQ otherwise.
    always_comb begin
        burst_start = (Htrans == TR_NONSEQ) && (Hburst[2:1] != 2'b00);
        abort       = (Htrans == TR_IDLE) || (Htrans == TR_NONSEQ) || (Hresp == RESP_ERR);
        case (Hburst[2:1])
            2'b01:   burst_len = 4'd3;
            2'b10:   burst_len = 4'd7;
            default: burst_len = 4'd15;
        endcase
        beats_nxt  = beats_left;
        burst_done = 1'b0;
        if (beats_left != 4'd0) begin
            if (abort) begin
                beats_nxt  = 4'd0;
                burst_done = 1'b1;
            end else if (Htrans == TR_SEQ) begin
                beats_nxt  = beats_left - 4'd1;
                burst_done = (beats_left == 4'd1);
            end
        end else if (burst_start) begin
            beats_nxt = burst_len;
        end
    end

    always_comb begin
        state_nxt = state;
        do_arb    = 1'b0;
        case (state)
            ARB: begin
                if (lock_ext[g_idx])  state_nxt = LOCK;
                else if (burst_start) state_nxt = BURST;
                else                  do_arb    = 1'b1;
            end
            BURST: begin
                if (lock_ext[g_idx]) begin
                    state_nxt = LOCK;
                end else if (burst_done) begin
                    state_nxt = ARB;
                    do_arb    = 1'b1;
                end
            end
            LOCK: begin
                if (!lock_ext[Hmaster]) begin
                    if (beats_nxt != 4'd0) begin
                        state_nxt = BURST;
                    end else begin
                        state_nxt = ARB;
                        do_arb    = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ARB;
                do_arb    = 1'b1;
            end
        endcase
    end

    // Everything advances only on accepted edges (Hready high).
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state      <= ARB;
            beats_left <= 4'd0;
            last_grant <= DEF_IDX;
            Hgrant     <= DEF_GRANT;
            Hmaster    <= DEF_IDX;
            Hmaster_d  <= DEF_IDX;
            Hmastlock  <= 1'b0;
        end else if (Hready) begin
            state      <= state_nxt;
            beats_left <= beats_nxt;
            Hmaster    <= g_idx;
            Hmaster_d  <= Hmaster;
            Hmastlock  <= lock_ext[g_idx];
            if (do_arb) begin
                Hgrant <= arb_grant;
                if (any_req) last_grant <= arb_idx;
            end
        end
    end

endmodule
